// File: rtl/cic_rate_bridge_if.sv
// Valid/ready sample stream used on both sides of cic_rate_bridge.
interface cic_rate_bridge_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/cic_rate_bridge.sv
// Single-clock valid/ready rate changer for the CIC chain.
// DnI=1: keep one of every R accepted samples (decimator).
// DnI=0: emit each accepted sample followed by R-1 filler beats (interpolator).
// Optional macro CIC_ZOH_EN: interpolator filler beats repeat the sample
// (zero-order hold) instead of being zero.
module cic_rate_bridge #(
    parameter int WIDTH    = 16,
    parameter int MAX_RATE = 16,
    parameter int DnI      = 1
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [$clog2(MAX_RATE):0]   rate_i,
    cic_rate_bridge_if.slave            in_s,
    cic_rate_bridge_if.master           out_m,
    output logic [$clog2(MAX_RATE)-1:0] phase_o,
    output logic                        rate_err_o
);
    localparam int RW = $clog2(MAX_RATE) + 1;
    localparam int PW = $clog2(MAX_RATE);
    localparam logic [RW-1:0] MAXR = RW'(MAX_RATE);
    localparam logic [RW-1:0] ONE  = RW'(1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t           state_q, state_d;
    logic [RW-1:0]    rate_q, rate_d;
    logic [RW-1:0]    beats_left_q, beats_left_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             rate_err_q, rate_err_d;
    logic             run_q, run_d;

    logic [RW-1:0]    rate_eff;
    logic             rate_bad;
    logic             phase_wrap;
    logic             in_ready;
    logic             accept;
    logic             out_xfer;

    // Sanitise the requested rate: 0 behaves as 1, oversize clamps to MAX_RATE.
    always_comb begin
        rate_bad = (rate_i == '0) || (rate_i > MAXR);
        if (rate_i == '0)
            rate_eff = ONE;
        else if (rate_i > MAXR)
            rate_eff = MAXR;
        else
            rate_eff = rate_i;
        phase_wrap = ({1'b0, phase_q} + ONE) == rate_q;
    end

    // Upstream ready; run_q holds it low for the first cycle out of reset.
    always_comb begin
        if (!run_q)
            in_ready = 1'b0;
        else if (DnI != 0)
            in_ready = (phase_q != '0) || !out_valid_q || out_m.ready;
        else
            in_ready = (state_q == IDLE) ||
                       ((beats_left_q == ONE) && out_valid_q && out_m.ready);
        accept   = in_s.valid && in_ready;
        out_xfer = out_valid_q && out_m.ready;
    end

    // Next-state logic for both rate-change directions.
    always_comb begin
        state_d      = state_q;
        rate_d       = rate_q;
        beats_left_d = beats_left_q;
        phase_d      = phase_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        rate_err_d   = rate_err_q;
        run_d        = 1'b1;

        if (DnI != 0) begin
            if (out_xfer)
                out_valid_d = 1'b0;
            if (accept) begin
                if (phase_q == '0) begin
                    rate_d      = rate_eff;
                    rate_err_d  = rate_err_q | rate_bad;
                    out_data_d  = in_s.data;
                    out_valid_d = 1'b1;
                    phase_d     = (rate_eff == ONE) ? '0 : PW'(1);
                end else begin
                    phase_d = phase_wrap ? '0 : phase_q + 1'b1;
                end
            end
        end else begin
            // An accept while in EMIT only happens on the last beat's transfer,
            // so the burst-start load below simply overrides the end-of-burst path.
            if (out_xfer) begin
                if (beats_left_q == ONE) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    phase_d     = '0;
                end else begin
                    beats_left_d = beats_left_q - ONE;
                    phase_d      = phase_q + 1'b1;
`ifdef CIC_ZOH_EN
                    out_data_d   = out_data_q;
`else
                    out_data_d   = '0;
`endif
                end
            end
            if (accept) begin
                state_d      = EMIT;
                rate_d       = rate_eff;
                rate_err_d   = rate_err_q | rate_bad;
                out_data_d   = in_s.data;
                out_valid_d  = 1'b1;
                phase_d      = '0;
                beats_left_d = rate_eff;
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= IDLE;
            rate_q       <= ONE;
            beats_left_q <= '0;
            phase_q      <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            rate_err_q   <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rate_q       <= rate_d;
            beats_left_q <= beats_left_d;
            phase_q      <= phase_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            rate_err_q   <= rate_err_d;
            run_q        <= run_d;
        end
    end

    assign in_s.ready  = in_ready;
    assign out_m.data  = out_data_q;
    assign out_m.valid = out_valid_q;
    assign phase_o     = phase_q;
    assign rate_err_o  = rate_err_q;
endmodule

// File: tb/tb_cic_rate_bridge.sv
// Bench for cic_rate_bridge: one decimator and one interpolator instance,
// each checked every cycle against a queue-based reference model.
module tb_cic_rate_bridge;
    localparam int W  = 16;
    localparam int MR = 16;
    localparam int RW = 5;
    localparam int PW = 4;
`ifdef CIC_ZOH_EN
    localparam bit ZOH = 1'b1;
`else
    localparam bit ZOH = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic [RW-1:0] rate_i;
    logic [PW-1:0] dph, iph;
    logic          derr, ierr;

    always #5 clk = ~clk;

    cic_rate_bridge_if #(.WIDTH(W)) din ();
    cic_rate_bridge_if #(.WIDTH(W)) dout ();
    cic_rate_bridge_if #(.WIDTH(W)) iin ();
    cic_rate_bridge_if #(.WIDTH(W)) iout ();

    cic_rate_bridge #(.WIDTH(W), .MAX_RATE(MR), .DnI(1)) u_dec (
        .clk(clk), .rstn(rstn), .rate_i(rate_i), .in_s(din), .out_m(dout),
        .phase_o(dph), .rate_err_o(derr));

    cic_rate_bridge #(.WIDTH(W), .MAX_RATE(MR), .DnI(0)) u_int (
        .clk(clk), .rstn(rstn), .rate_i(rate_i), .in_s(iin), .out_m(iout),
        .phase_o(iph), .rate_err_o(ierr));

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int dq[$];
    int iq[$];
    int dk = 0, dR = 1, iR = 1;
    bit derr_m = 0, ierr_m = 0, run_m = 0;
    bit dacc = 0, iacc = 0;
    int dlog[$];
    int ilog[$];

    function automatic int san(input int r);
        if (r == 0) return 1;
        if (r > MR) return MR;
        return r;
    endfunction

    function automatic bit bad(input int r);
        return (r == 0) || (r > MR);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_log(input string name, input int got[$], input int exp[$]);
        chk({name, "_len"}, got.size(), exp.size());
        foreach (exp[i])
            chk(name, (i < got.size()) ? got[i] : -1, exp[i]);
    endtask

    // Compare process: checks DUT state, then advances the model by the
    // handshakes that the coming rising edge will complete.
    always @(negedge clk) begin
        bit dxf, ixf;
        #1;
        if (!rstn) begin
            chk("rst_dec_valid", int'(dout.valid), 0);
            chk("rst_dec_data",  int'(dout.data), 0);
            chk("rst_dec_phase", int'(dph), 0);
            chk("rst_dec_err",   int'(derr), 0);
            chk("rst_dec_ready", int'(din.ready), 0);
            chk("rst_int_valid", int'(iout.valid), 0);
            chk("rst_int_data",  int'(iout.data), 0);
            chk("rst_int_phase", int'(iph), 0);
            chk("rst_int_err",   int'(ierr), 0);
            chk("rst_int_ready", int'(iin.ready), 0);
            dq.delete(); iq.delete();
            dk = 0; dR = 1; iR = 1;
            derr_m = 0; ierr_m = 0; run_m = 0;
            dacc = 0; iacc = 0;
        end else begin
            chk("dec_valid", int'(dout.valid), int'(dq.size() != 0));
            if (dq.size() != 0) chk("dec_data", int'(dout.data), dq[0]);
            chk("dec_phase", int'(dph), dk);
            chk("dec_ready", int'(din.ready),
                int'(run_m && (dk != 0 || dq.size() == 0 || dout.ready)));
            chk("dec_err", int'(derr), int'(derr_m));

            chk("int_valid", int'(iout.valid), int'(iq.size() != 0));
            if (iq.size() != 0) chk("int_data", int'(iout.data), iq[0]);
            chk("int_phase", int'(iph), (iq.size() != 0) ? iR - iq.size() : 0);
            chk("int_ready", int'(iin.ready),
                int'(run_m && (iq.size() == 0 || (iq.size() == 1 && iout.ready))));
            chk("int_err", int'(ierr), int'(ierr_m));

            // decimator: keep the first sample of each R-sample epoch
            dacc = din.valid && din.ready;
            dxf  = dout.valid && dout.ready;
            if (dxf) begin
                dlog.push_back(int'(dout.data));
                if (dq.size() != 0) void'(dq.pop_front());
            end
            if (dacc) begin
                if (dk == 0) begin
                    dR = san(int'(rate_i));
                    derr_m |= bad(int'(rate_i));
                    dq.push_back(int'(din.data));
                end
                dk = (dk + 1) % dR;
            end

            // interpolator: each sample becomes an R-beat burst
            iacc = iin.valid && iin.ready;
            ixf  = iout.valid && iout.ready;
            if (ixf) begin
                ilog.push_back(int'(iout.data));
                if (iq.size() != 0) void'(iq.pop_front());
            end
            if (iacc) begin
                iR = san(int'(rate_i));
                ierr_m |= bad(int'(rate_i));
                iq.push_back(int'(iin.data));
                for (int b = 1; b < iR; b++)
                    iq.push_back(ZOH ? int'(iin.data) : 0);
            end
            run_m = 1;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        tick();
        rstn = 1'b0;
        din.valid = 1'b0; iin.valid = 1'b0;
        dout.ready = 1'b1; iout.ready = 1'b1;
        dlog.delete(); ilog.delete();
        repeat (2) tick();
        rstn = 1'b1;
    endtask

    // Feed nd decimator samples (1,2,..) and ni interpolator samples
    // (0x0A,0x0B,..) with full downstream readiness; optionally switch
    // rate_i right after the first decimator acceptance.
    task automatic feed(input int nd, input int ni, input int cyc, input int newrate);
        int  dn = 0;
        int  inn = 0;
        bit  changed = 0;
        din.valid = (nd > 0); din.data = W'(1);
        iin.valid = (ni > 0); iin.data = W'('h0A);
        dout.ready = 1'b1; iout.ready = 1'b1;
        for (int c = 0; c < cyc; c++) begin
            tick();
            if (dacc) begin
                dn++;
                din.data = W'(dn + 1);
                if (dn >= nd) din.valid = 1'b0;
                if (newrate >= 0 && !changed) begin
                    rate_i  = RW'(newrate);
                    changed = 1;
                end
            end
            if (iacc) begin
                inn++;
                iin.data = W'('h0A + inn);
                if (inn >= ni) iin.valid = 1'b0;
            end
        end
    endtask

    initial begin
        int e[$];
        int rates[3];
        int dn;
        rates = '{1, 2, MR};
        rstn = 1'b0; rate_i = RW'(4);
        din.valid = 1'b0; din.data = '0; iin.valid = 1'b0; iin.data = '0;
        dout.ready = 1'b1; iout.ready = 1'b1;
        repeat (3) tick();

        // Basic decimate by 4 / interpolate by 4
        do_reset(); rate_i = RW'(4);
        feed(12, 2, 30, -1);
        e = '{1, 5, 9};
        chk_log("A_dec_out", dlog, e);
        if (ZOH) e = '{'h0A, 'h0A, 'h0A, 'h0A, 'h0B, 'h0B, 'h0B, 'h0B};
        else     e = '{'h0A, 0, 0, 0, 'h0B, 0, 0, 0};
        chk_log("A_int_out", ilog, e);

        // Decimator stall with a full output register
        do_reset(); rate_i = RW'(4);
        dn = 0; din.valid = 1'b1; din.data = W'(1); dout.ready = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (dacc) begin
                dn++;
                din.data = W'(dn + 1);
                if (dn >= 12) din.valid = 1'b0;
            end
            if (c == 10) begin
                chk("B_hold_data", int'(dout.data), 1);
                chk("B_stall_ready", int'(din.ready), 0);
                chk("B_stall_phase", int'(dph), 0);
            end
            if (c == 12) dout.ready = 1'b1;
        end
        e = '{1, 5, 9};
        chk_log("B_dec_out", dlog, e);

        // Mid-epoch rate change 4 -> 2
        do_reset(); rate_i = RW'(4);
        feed(10, 2, 30, 2);
        e = '{1, 5, 7, 9};
        chk_log("C_dec_out", dlog, e);
        if (ZOH) e = '{'h0A, 'h0A, 'h0A, 'h0A, 'h0B, 'h0B};
        else     e = '{'h0A, 0, 0, 0, 'h0B, 0};
        chk_log("C_int_out", ilog, e);
        chk("C_dec_err_clear", int'(derr), 0);
        chk("C_int_err_clear", int'(ierr), 0);

        // rate_i = 0 behaves as R=1 and sets the sticky error
        rate_i = '0; dlog.delete(); ilog.delete();
        feed(3, 1, 12, -1);
        e = '{1, 2, 3};
        chk_log("C_r0_dec_out", dlog, e);
        chk("C_r0_dec_err", int'(derr), 1);
        chk("C_r0_int_err", int'(ierr), 1);
        rate_i = RW'(2);
        feed(4, 1, 12, -1);
        chk("C_sticky_dec_err", int'(derr), 1);
        chk("C_sticky_int_err", int'(ierr), 1);

        // Oversize rate clamps to MAX_RATE
        do_reset(); rate_i = RW'(MR + 1);
        feed(20, 1, 40, -1);
        e = '{1, 17};
        chk_log("C_clamp_dec_out", dlog, e);
        chk("C_clamp_int_len", ilog.size(), MR);
        chk("C_clamp_dec_err", int'(derr), 1);
        chk("C_clamp_int_err", int'(ierr), 1);

        // Reset during beat 3 of an R=8 burst
        do_reset(); rate_i = RW'(8);
        iin.valid = 1'b1; iin.data = W'('h33);
        for (int c = 0; c < 20; c++) begin
            tick();
            if (iacc) iin.valid = 1'b0;
            if (ilog.size() == 2) break;
        end
        chk("D_beat3_phase", int'(iph), 2);
        rstn = 1'b0;
        #2;
        chk("D_rst_valid", int'(iout.valid), 0);
        tick();
        rstn = 1'b1;
        dlog.delete(); ilog.delete();
        feed(0, 1, 15, -1);
        if (ZOH) e = '{'h0A, 'h0A, 'h0A, 'h0A, 'h0A, 'h0A, 'h0A, 'h0A};
        else     e = '{'h0A, 0, 0, 0, 0, 0, 0, 0};
        chk_log("D_fresh_burst", ilog, e);

        // Random traffic and backpressure for R in {1, 2, MAX_RATE}
        foreach (rates[r]) begin
            do_reset(); rate_i = RW'(rates[r]);
            for (int c = 0; c < 800; c++) begin
                tick();
                din.valid  = ($urandom_range(3) != 0);
                din.data   = W'($urandom);
                iin.valid  = ($urandom_range(3) == 0);
                iin.data   = W'($urandom);
                dout.ready = ($urandom_range(2) != 0);
                iout.ready = ($urandom_range(4) != 0);
                if ($urandom_range(15) == 0)
                    rate_i = RW'(rates[$urandom_range(2)]);
            end
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cic_rate_bridge.md
Name: cic_rate_bridge

Overview:
- Single-clock, valid/ready streaming rate changer for the CIC filter chain.
- Decimation mode (DnI=1): forwards one of every R accepted input samples.
- Interpolation mode (DnI=0): emits each accepted input sample followed by R-1 zero samples.
- Rate R is selectable at run time. The rate epoch is tracked by a counter instead of a second clock, so the integrator and comb sections can share one clock domain with clock-enable style flow control.

Parameters:
- WIDTH, 16: sample width in bits.
- MAX_RATE, 16: largest supported rate; power of 2, at least 2.
- DnI, 1: 1 = decimator, 0 = interpolator (elaboration-time).

Ports:
- clk  input  1  single system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- rate_i  input  $clog2(MAX_RATE)+1  requested rate R.
- in_data  input  WIDTH  upstream sample.
- in_valid  input  1  upstream sample valid.
- in_ready  output  1  block accepts in_data this cycle.
- out_data  output  WIDTH  downstream sample.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- phase_o  output  $clog2(MAX_RATE)  current position within the rate epoch.
- rate_err_o  output  1  sticky flag: an out-of-range rate was latched.

Behaviour:
- Transfer rules:
  - A transfer occurs when valid && ready are both high on a rising clk edge.
  - out_valid never drops without a completed output transfer.
  - out_data stays stable while out_valid && !out_ready.
- Reset (async, rstn low), all outputs and state cleared:
  - out_valid=0, out_data=0, phase_o=0, rate_err_o=0, in_ready=0.
  - Latched rate = 1; state IDLE.
  - First in_ready=1 occurs on the cycle after rstn deasserts.
  - Reset mid-burst or mid-epoch discards all pending data; nothing is emitted afterwards.
- Rate latch:
  - rate_i is sampled only at epoch start: decimation when phase=0 and an input is accepted; interpolation on burst start.
  - rate_i=0 is used as 1 and sets rate_err_o.
  - rate_i>MAX_RATE is clamped to MAX_RATE and sets rate_err_o.
  - Changes to rate_i mid-epoch have no effect until the next epoch.
  - R=1 makes the block a registered pass-through.
- Decimation (DnI=1):
  - phase counts accepted inputs from 0 to R-1, then wraps to 0.
  - The input accepted at phase 0 is loaded into the output register, giving out_valid one cycle after acceptance (latency 1).
  - Inputs accepted at phases 1..R-1 are dropped.
  - in_ready = (phase!=0) || !out_valid || out_ready. Dropped samples are never stalled; a kept sample waits only when the output register is full and not draining.
  - Simultaneous output drain and phase-0 accept: the register reloads and out_valid stays 1 (full throughput).
- Interpolation (DnI=0), states IDLE and EMIT:
  - IDLE: in_ready=1. An accepted input loads the output register with in_data, sets out_valid=1, phase=0, beats_left=R, and moves to EMIT.
  - EMIT: on each output transfer, beats_left decrements and phase increments; out_data for beats 2..R is 0.
  - When the last beat transfers, go to IDLE, unless an input is accepted in the same cycle.
  - in_ready in EMIT = (beats_left==1) && out_valid && out_ready. This allows back-to-back bursts with no bubble.
  - Steady-state output rate = input rate × R.
- Arithmetic: no sample arithmetic; data is passed unchanged.
- phase_o width is $clog2(MAX_RATE); the phase counter wraps modulo the latched R.

Optional Feature:
- Macro name: CIC_ZOH_EN.
- Defined, interpolation mode: zero-order hold. Beats 2..R repeat the latched input sample instead of 0.
- Defined, decimation mode: unaffected.
- Undefined: zero-stuffing exactly as described in Behaviour.

Test Plan:
- Decimation, R=4, input 1,2,3,…,12 with continuous valid, out_ready=1 -> output 1,5,9, each one cycle after its acceptance; in_ready stays 1 throughout.
- Decimation, R=4, out_ready=0 for 10 cycles after the first kept sample -> out_data holds 1; in_ready drops only when phase wraps to 0 with the register full; no sample is lost or duplicated once out_ready=1.
- Interpolation, R=4, inputs 0x0A then 0x0B back-to-back, out_ready=1 -> output 0x0A,0,0,0,0x0B,0,0,0 with no bubbles. With CIC_ZOH_EN: 0x0A×4 then 0x0B×4.
- rate_i changes from 4 to 2 mid-epoch -> current epoch completes with R=4; the next epoch uses R=2. rate_i=0 -> R=1 behaviour and rate_err_o=1 (sticky). rate_i=MAX_RATE+1 -> clamped and rate_err_o=1.
- Interpolation, R=8: assert rstn=0 at beat 3 -> out_valid=0 immediately; after release, the next input starts a fresh burst at phase 0.
- Random valid/ready backpressure, both modes, R in {1,2,MAX_RATE} -> a scoreboard matches the reference decimate/zero-stuff model exactly.
